ram_stream_reader: RTL and testbench

- Read-side engine for a simple dual-port RAM.
- Accepts a command (start address, word count) and issues reads on the RAM read port (enable, address; registered data with 1-cycle latency).
- Emits the words in order on a valid/ready stream with full backpressure support.
- Pairs with the producer that fills the RAM via the write port. Used to drain staging buffers toward the host/AXI side.

---
 rtl/ram_stream_reader_pkg.sv | 16 +
 rtl/ram_stream_reader_fifo.sv | 66 ++++++
 rtl/ram_stream_reader.sv | 125 ++++++++++++
 tb/tb_ram_stream_reader.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader and its output buffer.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int BUF_DEPTH    = 4;
    localparam int CNT_WIDTH    = $clog2(BUF_DEPTH) + 1;
    // Buffered words plus reads still in flight may never exceed this.
    localparam int CREDIT_LIMIT = BUF_DEPTH;

endpackage

// File: rtl/ram_stream_reader_fifo.sv
// 4-entry output buffer carrying {last, data}; head is visible the cycle after push.
// Push and pop in the same cycle leave the count unchanged; pop on empty is ignored.
module ram_stream_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  push_last,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  head_valid,
    output logic                  head_last,
    output logic [DATA_WIDTH-1:0] head_data
);
    localparam int PTR_WIDTH = $clog2(BUF_DEPTH);

    logic [DATA_WIDTH:0]  mem_q [BUF_DEPTH];
    logic [DATA_WIDTH:0]  mem_d [BUF_DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 pop_eff;

    assign pop_eff = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_eff) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_last  = mem_q[rd_ptr_q][DATA_WIDTH];
    assign head_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop_eff && (count_q == CNT_WIDTH'(BUF_DEPTH))));

endmodule

// File: rtl/ram_stream_reader.sv
// Reads cmd_len words from a 1-cycle-latency RAM port and streams them out; first m_valid 3 cycles after accept.
// Reads are issued only while buffered plus in-flight words stay below the buffer depth, so m_ready may stall freely.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    output logic                  ram_enb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_dob,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);
    state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic                  busy_q, busy_d;
    logic                  pend_q, pend_d;
    logic                  pend_last_q, pend_last_d;
    logic                  issue;
    logic                  pop;
    logic                  credit_ok;
    logic [CNT_WIDTH-1:0]  occ;
    logic [CNT_WIDTH-1:0]  occ_next;

    assign pop       = m_valid && m_ready;
    assign credit_ok = (occ + CNT_WIDTH'(pend_q)) < CNT_WIDTH'(CREDIT_LIMIT);
    // Drain exit looks one edge ahead so done lands right after the last handshake.
    assign occ_next  = occ + CNT_WIDTH'(pend_q) - CNT_WIDTH'(pop);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        issue       = 1'b0;
        cmd_ready   = 1'b0;
        done        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    rem_d   = cmd_len;
                    busy_d  = 1'b1;
                    state_d = (cmd_len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((occ_next == '0) && !pend_q) begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d      = issue;
        pend_last_d = issue && (rem_q == LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
        end
    end

    assign ram_enb   = issue;
    assign ram_addrb = addr_q;
    assign busy      = busy_q;

    ram_stream_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (pend_q),
        .push_last  (pend_last_q),
        .push_data  (ram_dob),
        .pop        (pop),
        .count      (occ),
        .head_valid (m_valid),
        .head_last  (m_last),
        .head_data  (m_data)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and randomized bench for ram_stream_reader with a behavioural RAM and stream model.
module tb_ram_stream_reader;
    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int LW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          ram_enb;
    logic [AW-1:0] ram_addrb;
    logic [DW-1:0] ram_dob;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];
    int            total = 0;
    int            bad = 0;
    int            issued = 0;
    int            hs = 0;
    int            done_cnt = 0;
    int            mvalid_cnt = 0;
    int            addr_log[$];
    logic [DW:0]   word_log[$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    int            rdy_mode = 0;
    int            stall_left = 0;

    always #5 clk = ~clk;

    ram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_dob   (ram_dob),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done)
    );

    // RAM read port: registered data, holds its last value when not enabled.
    always @(posedge clk) begin
        if (ram_enb) ram_dob <= mem[ram_addrb];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: logs issues and handshakes, checks hold-under-stall and credit.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall m_valid held", m_valid, 1);
                check("stall m_data held", m_data, prev_data);
                check("stall m_last held", m_last, prev_last);
            end
            check("words in flight <= 4", (issued - hs) <= 4, 1);
            if (ram_enb) begin
                addr_log.push_back(int'(ram_addrb));
                issued++;
            end
            if (m_valid && m_ready) begin
                word_log.push_back({m_last, m_data});
                hs++;
            end
            if (m_valid) mvalid_cnt++;
            if (done) done_cnt++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic clear_logs();
        issued = 0;
        hs = 0;
        done_cnt = 0;
        mvalid_cnt = 0;
        addr_log.delete();
        word_log.delete();
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, " cmd_ready"}, cmd_ready, 1);
        check({pfx, " ram_enb"}, ram_enb, 0);
        check({pfx, " ram_addrb"}, ram_addrb, 0);
        check({pfx, " m_valid"}, m_valid, 0);
        check({pfx, " m_data"}, m_data, 0);
        check({pfx, " m_last"}, m_last, 0);
        check({pfx, " busy"}, busy, 0);
        check({pfx, " done"}, done, 0);
    endtask

    task automatic set_ready();
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: m_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (hs >= 1 && stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else begin
                    m_ready = 1'b1;
                end
            end
        endcase
    endtask

    // Runs one command and compares everything seen against the addressing/ordering rules.
    task automatic run_cmd(input string name, input int a, input int n, input int mode);
        int ea;
        clear_logs();
        rdy_mode   = mode;
        stall_left = 6;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = AW'(a);
        cmd_len   = LW'(n);
        set_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 600 && done_cnt == 0; c++) begin
            set_ready();
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check({name, " single done"}, done_cnt, 1);
        check({name, " reads issued"}, issued, n);
        check({name, " words delivered"}, hs, n);
        for (int i = 0; i < n && i < addr_log.size(); i++) begin
            ea = (a + i) % DEPTH;
            check($sformatf("%s addr[%0d]", name, i), addr_log[i], ea);
        end
        for (int i = 0; i < n && i < word_log.size(); i++) begin
            ea = (a + i) % DEPTH;
            check($sformatf("%s word[%0d]", name, i), word_log[i], {(i == n - 1), mem[ea]});
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 16);
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        rst = 1'b0;

        // Cycle-exact timing of a short command.
        clear_logs();
        m_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = AW'(3);
        cmd_len   = LW'(4);
        @(negedge clk);
        check("t1 cmd_ready@T", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("t1 ram_enb@T+%0d", k), ram_enb, (k <= 4));
            if (k <= 4) check($sformatf("t1 ram_addrb@T+%0d", k), ram_addrb, 2 + k);
            check($sformatf("t1 m_valid@T+%0d", k), m_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) begin
                check($sformatf("t1 m_data@T+%0d", k), m_data, 16 + k);
                check($sformatf("t1 m_last@T+%0d", k), m_last, (k == 6));
            end
            check($sformatf("t1 done@T+%0d", k), done, (k == 7));
            check($sformatf("t1 busy@T+%0d", k), busy, (k <= 6));
            check($sformatf("t1 cmd_ready@T+%0d", k), cmd_ready, (k == 8));
        end

        run_cmd("t2 wrap", 30, 4, 0);
        run_cmd("t3 backpressure", 0, 8, 2);

        // Zero-length command.
        clear_logs();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = AW'(7);
        cmd_len   = '0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("t4 done@T+%0d", k), done, (k == 1));
            check($sformatf("t4 busy@T+%0d", k), busy, (k == 1));
            check($sformatf("t4 cmd_ready@T+%0d", k), cmd_ready, (k >= 2));
        end
        check("t4 no reads", issued, 0);
        check("t4 no m_valid", mvalid_cnt, 0);

        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        run_cmd("t5 full random", 5, DEPTH, 1);

        // Reset in the middle of a command.
        clear_logs();
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_addr  = AW'(12);
        cmd_len   = LW'(10);
        m_ready   = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && !(ram_enb && issued == 2); c++) begin
            @(posedge clk); #1;
        end
        check("t6 third issue reached", (ram_enb && issued == 2), 1);
        rst = 1'b1;
        #1;
        reset_checks("t6 async reset");
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_logs();
        repeat (6) @(posedge clk);
        #1;
        check("t6 no m_valid after reset", mvalid_cnt, 0);
        check("t6 no done after reset", done_cnt, 0);
        check("t6 no reads after reset", issued, 0);
        run_cmd("t6 restart", 20, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
